// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the column frame writer: FSM states, header field layout
// and the broadcast column ID.
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam int HDR_IDX_LSB = 0;
  localparam int HDR_IDX_W   = 5;
  localparam int HDR_COL_LSB = 8;
  localparam int HDR_COL_W   = 5;
  localparam int HDR_PAR_BIT = 15;

  localparam logic [4:0] BROADCAST_COL = 5'd31;

  // A frame belongs to this column when addressed directly or by broadcast.
  function automatic logic col_hit(input logic [4:0] col, input logic [4:0] id);
    return (col == id) || (col == BROADCAST_COL);
  endfunction

endpackage

// File: rtl/frame_strobe_decode.sv
// Registered one-hot FrameStrobe decoder with a combinational out-of-range flag
// for frame indices beyond the strobe chain.
module frame_strobe_decode #(
  parameter int MaxFramesPerCol = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 idx,
  input  logic                       en,
  output logic [MaxFramesPerCol-1:0] strobe,
  output logic                       out_of_range
);

  assign out_of_range = (int'(idx) >= MaxFramesPerCol);

  // Registered stage: strobe_p1 is the FrameStrobe pulse itself
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= '0;
    end else begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        strobe[i] <= en && !out_of_range && (int'(idx) == i);
      end
    end
  end

endmodule

// File: rtl/frame_strobe_driver.sv
// Per-column configuration frame writer: header + NumberOfRows data words, then one
// FrameStrobe pulse. Define FRAME_PARITY_EN to check header bit 15 as frame even parity.
module frame_strobe_driver
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16,
  parameter int ColumnID        = 0
) (
  input  logic                                    UserCLK,
  input  logic                                    rst,
  input  logic                                    w_valid,
  output logic                                    w_ready,
  input  logic                                    w_hdr,
  input  logic [FrameBitsPerRow-1:0]              w_data,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    busy,
  output logic                                    err
);

  localparam int         CNT_W  = $clog2(NumberOfRows + 1);
  localparam logic [4:0] COL_ID = 5'(ColumnID);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] row_cnt;
  logic [4:0]       frame_idx;
  logic [4:0]       hdr_col;
  logic             xfer, hdr_xfer, data_xfer;
  logic             col_match, last_row, row_we;
  logic             strobe_vld_p0;
  logic             oor;
  logic             par_bad;
  logic             err_nxt;

  assign w_ready   = (state == ST_IDLE) || (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign xfer      = w_valid && w_ready;
  assign hdr_xfer  = xfer && w_hdr;
  assign data_xfer = xfer && !w_hdr;
  assign col_match = col_hit(hdr_col, COL_ID);
  assign last_row  = (row_cnt == CNT_W'(NumberOfRows - 1));

`ifdef FRAME_PARITY_EN
  logic par_exp;
  logic par_acc;

  always_ff @(posedge UserCLK) begin
    if (hdr_xfer) begin
      par_exp <= w_data[HDR_PAR_BIT];
      par_acc <= 1'b0;
    end else if (state == ST_LOAD && data_xfer) begin
      par_acc <= par_acc ^ (^w_data);
    end
  end

  assign par_bad = (par_acc != par_exp);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge UserCLK) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    row_we        = 1'b0;
    err_nxt       = 1'b0;
    strobe_vld_p0 = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hdr_xfer)       state_nxt = ST_LOAD;
        else if (data_xfer) err_nxt   = 1'b1;
      end
      ST_LOAD: begin
        // A header mid-frame restarts loading; rows already written are kept.
        if (hdr_xfer) begin
          err_nxt = 1'b1;
        end else if (data_xfer) begin
          row_we = col_match;
          if (last_row) state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt     = ST_STROBE;
        strobe_vld_p0 = col_match && !par_bad;
        err_nxt       = col_match && (oor || par_bad);
      end
      ST_STROBE: state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      row_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= err_nxt;
      if (hdr_xfer)                            row_cnt <= '0;
      else if (state == ST_LOAD && data_xfer)  row_cnt <= row_cnt + 1'b1;
    end
  end

  always_ff @(posedge UserCLK) begin
    if (hdr_xfer) begin
      frame_idx <= w_data[HDR_IDX_LSB +: HDR_IDX_W];
      hdr_col   <= w_data[HDR_COL_LSB +: HDR_COL_W];
    end
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      FrameData <= '0;
    end else if (row_we) begin
      for (int r = 0; r < NumberOfRows; r++) begin
        if (row_cnt == CNT_W'(r)) FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= w_data;
      end
    end
  end

  // SETUP -> STROBE boundary: decoder registers the pulse for the STROBE cycle
  frame_strobe_decode #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_decode (
    .clk          (UserCLK),
    .rst          (rst),
    .idx          (frame_idx),
    .en           (strobe_vld_p0),
    .strobe       (FrameStrobe),
    .out_of_range (oor)
  );

endmodule

// File: tb/tb_frame_strobe_driver.sv
// Scoreboard bench for frame_strobe_driver: frame expectations are queued as words
// are driven and checked as the FSM walks SETUP/STROBE/HOLD.
module tb_frame_strobe_driver;

  localparam int MF  = 20;
  localparam int W   = 32;
  localparam int NR  = 16;
  localparam int CID = 0;
`ifdef FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic            UserCLK = 1'b0;
  logic            rst = 1'b1;
  logic            w_valid = 1'b0;
  logic            w_hdr = 1'b0;
  logic [W-1:0]    w_data = '0;
  logic            w_ready;
  logic [NR*W-1:0] FrameData;
  logic [MF-1:0]   FrameStrobe;
  logic            busy;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;

  logic [NR*W-1:0] model_fd = '0;
  logic [NR*W-1:0] exp_fd_q[$];
  logic [MF-1:0]   exp_strb_q[$];
  logic            exp_err_q[$];
  int              exp_errcnt_q[$];

  frame_strobe_driver #(
    .MaxFramesPerCol(MF),
    .FrameBitsPerRow(W),
    .NumberOfRows(NR),
    .ColumnID(CID)
  ) dut (
    .UserCLK     (UserCLK),
    .rst         (rst),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_hdr       (w_hdr),
    .w_data      (w_data),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic step();
    @(posedge UserCLK);
    #1;
    if (err === 1'b1) err_seen++;
  endtask

  function automatic logic [31:0] make_hdr(input logic [4:0] col, input logic [4:0] idx,
                                           input logic par);
    return {16'h0, par, 2'b00, col, 3'b000, idx};
  endfunction

  // Drives a header and n rows; a full frame (n == NR) queues its expectations.
  task automatic send_frame(input logic [4:0] col, input logic [4:0] idx,
                            input logic [31:0] base, input int n, input bit flip,
                            input int extra_err);
    logic          par;
    logic          match;
    logic          ee;
    logic [31:0]   d;
    logic [MF-1:0] one;
    logic [MF-1:0] es;
    par = 1'b0;
    for (int r = 0; r < n; r++) begin
      d   = base + 32'(r);
      par = par ^ (^d);
    end
    match    = (col == 5'(CID)) || (col == 5'd31);
    err_seen = 0;
    w_valid  = 1'b1;
    w_hdr    = 1'b1;
    w_data   = make_hdr(col, idx, par ^ flip);
    step();
    for (int r = 0; r < n; r++) begin
      d      = base + 32'(r);
      w_hdr  = 1'b0;
      w_data = d;
      if (match) model_fd[r*W +: W] = d;
      step();
    end
    if (n == NR) begin
      w_valid = 1'b0;
      w_hdr   = 1'b0;
      one     = 1;
      es      = (match && int'(idx) < MF && !(PAR_EN && flip)) ? (one << idx) : '0;
      ee      = match && (int'(idx) >= MF || (PAR_EN && flip));
      exp_fd_q.push_back(model_fd);
      exp_strb_q.push_back(es);
      exp_err_q.push_back(ee);
      exp_errcnt_q.push_back(extra_err + (ee ? 1 : 0));
    end
  endtask

  // Called in the SETUP cycle right after the last data word transferred.
  task automatic check_frame(input string name);
    logic [NR*W-1:0] efd;
    logic [MF-1:0]   es;
    logic            ee;
    int              ecnt;
    efd  = exp_fd_q.pop_front();
    es   = exp_strb_q.pop_front();
    ee   = exp_err_q.pop_front();
    ecnt = exp_errcnt_q.pop_front();
    n_cmp++;
    if (FrameData !== efd) begin
      n_bad++;
      $display("FAIL %s framedata: got %h want %h", name, FrameData, efd);
    end
    n_cmp++;
    if (FrameStrobe !== '0 || w_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s setup: strobe %h ready %b busy %b want 0/0/1", name, FrameStrobe, w_ready, busy);
    end
    step();
    n_cmp++;
    if (FrameStrobe !== es) begin
      n_bad++;
      $display("FAIL %s strobe: got %h want %h", name, FrameStrobe, es);
    end
    n_cmp++;
    if (err !== ee) begin
      n_bad++;
      $display("FAIL %s strobe_err: got %b want %b", name, err, ee);
    end
    step();
    n_cmp++;
    if (FrameStrobe !== '0 || w_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s hold: strobe %h ready %b want 0/0", name, FrameStrobe, w_ready);
    end
    step();
    n_cmp++;
    if (w_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: ready %b busy %b want 1/0", name, w_ready, busy);
    end
    n_cmp++;
    if (err_seen !== ecnt) begin
      n_bad++;
      $display("FAIL %s err_count: got %0d want %0d", name, err_seen, ecnt);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    w_valid = 1'b0;
    step();
    step();
    rst      = 1'b0;
    model_fd = '0;
    n_cmp++;
    if (w_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || FrameStrobe !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready %b busy %b err %b strobe %h want 1/0/0/0",
               w_ready, busy, err, FrameStrobe);
    end
    n_cmp++;
    if (FrameData !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", FrameData);
    end
  endtask

  task automatic test_basic();
    send_frame(5'(CID), 5'd3, 32'h1000, NR, 1'b0, 0);
    check_frame("basic");
  endtask

  task automatic test_broadcast();
    send_frame(5'd31, 5'd19, 32'h2000, NR, 1'b0, 0);
    check_frame("broadcast");
  endtask

  task automatic test_other_col();
    send_frame(5'(CID + 1), 5'd5, 32'h3000, NR, 1'b0, 0);
    check_frame("other_col");
  endtask

  task automatic test_idle_data();
    w_valid = 1'b1;
    w_hdr   = 1'b0;
    w_data  = 32'hDEAD_BEEF;
    step();
    w_valid = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || w_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_data: err %b busy %b ready %b want 1/0/1", err, busy, w_ready);
    end
    step();
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_data_after: err %b busy %b want 0/0", err, busy);
    end
  endtask

  task automatic test_abort();
    send_frame(5'(CID), 5'd7, 32'h4000, 5, 1'b0, 0);
    send_frame(5'(CID + 1), 5'd9, 32'h5000, NR, 1'b0, 1);
    check_frame("abort_keep_rows");
    send_frame(5'(CID), 5'd7, 32'h4100, 5, 1'b0, 0);
    send_frame(5'(CID), 5'd8, 32'h4200, NR, 1'b0, 1);
    check_frame("abort_full");
  endtask

  task automatic test_out_of_range();
    send_frame(5'(CID), 5'd25, 32'h6000, NR, 1'b0, 0);
    check_frame("out_of_range");
  endtask

  task automatic test_parity();
    send_frame(5'(CID), 5'd4, 32'h8000, NR, 1'b0, 0);
    check_frame("parity_ok");
    send_frame(5'(CID), 5'd6, 32'h8100, NR, 1'b1, 0);
    check_frame("parity_flip");
  endtask

  task automatic test_rst_setup();
    logic [NR*W-1:0] efd;
    logic [MF-1:0]   es;
    logic            ee;
    int              ecnt;
    int              stray;
    send_frame(5'(CID), 5'd2, 32'h7000, NR, 1'b0, 0);
    efd  = exp_fd_q.pop_front();
    es   = exp_strb_q.pop_front();
    ee   = exp_err_q.pop_front();
    ecnt = exp_errcnt_q.pop_front();
    n_cmp++;
    if (busy !== 1'b1 || FrameData !== efd) begin
      n_bad++;
      $display("FAIL rst_setup_pre: busy %b data %h want 1/%h", busy, FrameData, efd);
    end
    rst = 1'b1;
    step();
    rst      = 1'b0;
    model_fd = '0;
    n_cmp++;
    if (busy !== 1'b0 || w_ready !== 1'b1 || FrameStrobe !== '0) begin
      n_bad++;
      $display("FAIL rst_setup_post: busy %b ready %b strobe %h want 0/1/0 (strobe was due %h)",
               busy, w_ready, FrameStrobe, es);
    end
    n_cmp++;
    if (FrameData !== '0) begin
      n_bad++;
      $display("FAIL rst_setup_data: got %h want 0", FrameData);
    end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (FrameStrobe !== '0 || err !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_bad++;
      $display("FAIL rst_setup_stray: got %0d active cycles want 0 (err due %b cnt %0d)",
               stray, ee, ecnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_broadcast();
    test_other_col();
    test_idle_data();
    test_abort();
    test_out_of_range();
    test_parity();
    test_rst_setup();
    test_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
